// File: rtl/bulls_cows_engine_if.sv
// Keypad/answer/score bundle for bulls_cows_engine; the front end drives the
// master side and the engine is the slave.
interface bulls_cows_engine_if #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 10
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  clr;
    logic                  answer_load;
    logic [4*DIGITS-1:0]   answer;
    logic [4*DIGITS-1:0]   guess_out;
    logic [CW-1:0]         entry_cnt;
    logic [CW-1:0]         strike;
    logic [CW-1:0]         ball;
    logic                  score_valid;
    logic [TW-1:0]         tries_used;
    logic                  busy;
    logic                  win;
    logic                  lose;

    modport master (
        output key_valid, key_code, clr, answer_load, answer,
        input  guess_out, entry_cnt, strike, ball, score_valid,
               tries_used, busy, win, lose
    );

    modport slave (
        input  key_valid, key_code, clr, answer_load, answer,
        output guess_out, entry_cnt, strike, ball, score_valid,
               tries_used, busy, win, lose
    );
endinterface

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows engine: assembles keypad digits into a guess, scores it one
// position per cycle and tracks attempts. Optional macro BCE_DUP_REJECT_EN drops repeated digits.
module bulls_cows_engine #(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bulls_cows_engine_if.slave    bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_WIN, S_LOSE} state_e;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] answer_q, answer_d;
    logic [4*DIGITS-1:0] guess_q, guess_d;
    logic [CW-1:0]       entry_cnt_q, entry_cnt_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       strike_acc_q, strike_acc_d;
    logic [CW-1:0]       ball_acc_q, ball_acc_d;
    logic [CW-1:0]       strike_q, strike_d;
    logic [CW-1:0]       ball_q, ball_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic                score_valid_q, score_valid_d;
    logic                busy_q, busy_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;

    logic                load_s, dup_s, key_ok_s, hit_strike_s, hit_ball_s;
    logic [CW-1:0]       strike_fin_s, ball_fin_s;
    logic [TW-1:0]       tries_inc_s;

    // Position 0 is the most significant nibble.
    function automatic logic [3:0] nib(input logic [4*DIGITS-1:0] v, input int p);
        nib = v[4*(DIGITS-1-p) +: 4];
    endfunction

    // Per-cycle scoring of the position selected by idx_q.
    always_comb begin
        hit_strike_s = 1'b0;
        hit_ball_s   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            hit_strike_s = hit_strike_s | ((idx_q == CW'(i)) & (nib(guess_q, i) == nib(answer_q, i)));
            for (int j = 0; j < DIGITS; j++) begin
                hit_ball_s = hit_ball_s | ((idx_q == CW'(i)) & (j != i) &
                                           (nib(guess_q, i) == nib(answer_q, j)));
            end
        end
        hit_ball_s   = hit_ball_s & ~hit_strike_s;
        strike_fin_s = strike_acc_q + CW'(hit_strike_s);
        ball_fin_s   = ball_acc_q + CW'(hit_ball_s);
        tries_inc_s  = (tries_q == TW'(MAX_TRIES)) ? tries_q : tries_q + TW'(1);
    end

    // Key qualification, including the optional repeated-digit filter.
    always_comb begin
`ifdef BCE_DUP_REJECT_EN
        dup_s = 1'b0;
        for (int p = 0; p < DIGITS; p++) begin
            dup_s = dup_s | ((CW'(p) < entry_cnt_q) & (nib(guess_q, p) == bus.key_code));
        end
`else
        dup_s = 1'b0;
`endif
        load_s   = bus.answer_load & (state_q != S_CHECK);
        key_ok_s = bus.key_valid & ~bus.clr & (bus.key_code <= 4'd9) & ~dup_s;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        answer_d      = answer_q;
        guess_d       = guess_q;
        entry_cnt_d   = entry_cnt_q;
        idx_d         = idx_q;
        strike_acc_d  = strike_acc_q;
        ball_acc_d    = ball_acc_q;
        strike_d      = strike_q;
        ball_d        = ball_q;
        tries_d       = tries_q;
        score_valid_d = 1'b0;
        if (load_s) begin
            answer_d    = bus.answer;
            guess_d     = {DIGITS{4'hF}};
            entry_cnt_d = {CW{1'b0}};
            tries_d     = {TW{1'b0}};
            strike_d    = {CW{1'b0}};
            ball_d      = {CW{1'b0}};
            state_d     = S_ENTRY;
        end else begin
            case (state_q)
                S_ENTRY: begin
                    if (bus.clr) begin
                        guess_d     = {DIGITS{4'hF}};
                        entry_cnt_d = {CW{1'b0}};
                    end else if (key_ok_s) begin
                        for (int p = 0; p < DIGITS; p++) begin
                            if (entry_cnt_q == CW'(p)) begin
                                guess_d[4*(DIGITS-1-p) +: 4] = bus.key_code;
                            end else begin
                                guess_d[4*(DIGITS-1-p) +: 4] = guess_q[4*(DIGITS-1-p) +: 4];
                            end
                        end
                        entry_cnt_d = entry_cnt_q + CW'(1);
                        if (entry_cnt_q == CW'(DIGITS - 1)) begin
                            state_d      = S_CHECK;
                            idx_d        = {CW{1'b0}};
                            strike_acc_d = {CW{1'b0}};
                            ball_acc_d   = {CW{1'b0}};
                        end else begin
                            state_d = S_ENTRY;
                        end
                    end else begin
                        state_d = S_ENTRY;
                    end
                end
                S_CHECK: begin
                    if (idx_q == CW'(DIGITS - 1)) begin
                        strike_d      = strike_fin_s;
                        ball_d        = ball_fin_s;
                        score_valid_d = 1'b1;
                        tries_d       = tries_inc_s;
                        guess_d       = {DIGITS{4'hF}};
                        entry_cnt_d   = {CW{1'b0}};
                        if (strike_fin_s == CW'(DIGITS)) begin
                            state_d = S_WIN;
                        end else if (tries_inc_s == TW'(MAX_TRIES)) begin
                            state_d = S_LOSE;
                        end else begin
                            state_d = S_ENTRY;
                        end
                    end else begin
                        idx_d        = idx_q + CW'(1);
                        strike_acc_d = strike_fin_s;
                        ball_acc_d   = ball_fin_s;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_WIN:   state_d = S_WIN;
                S_LOSE:  state_d = S_LOSE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_CHECK);
        win_d  = (state_d == S_WIN);
        lose_d = (state_d == S_LOSE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            answer_q      <= {(4*DIGITS){1'b0}};
            guess_q       <= {DIGITS{4'hF}};
            entry_cnt_q   <= {CW{1'b0}};
            idx_q         <= {CW{1'b0}};
            strike_acc_q  <= {CW{1'b0}};
            ball_acc_q    <= {CW{1'b0}};
            strike_q      <= {CW{1'b0}};
            ball_q        <= {CW{1'b0}};
            tries_q       <= {TW{1'b0}};
            score_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            answer_q      <= answer_d;
            guess_q       <= guess_d;
            entry_cnt_q   <= entry_cnt_d;
            idx_q         <= idx_d;
            strike_acc_q  <= strike_acc_d;
            ball_acc_q    <= ball_acc_d;
            strike_q      <= strike_d;
            ball_q        <= ball_d;
            tries_q       <= tries_d;
            score_valid_q <= score_valid_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign bus.guess_out   = guess_q;
    assign bus.entry_cnt   = entry_cnt_q;
    assign bus.strike      = strike_q;
    assign bus.ball        = ball_q;
    assign bus.score_valid = score_valid_q;
    assign bus.tries_used  = tries_q;
    assign bus.busy        = busy_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
endmodule
